// File: rtl/instr_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_ram_loader
//  Description : Assembles serial program bytes into 16-bit instruction words
//                and writes them into an instruction RAM, one word per session slot.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_ram_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_data,
    output logic              ram_enable,
    output logic              ram_write_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   c_FULL     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addrCnt;
    logic [ADDR_W:0]   r_remaining;
    logic [7:0]        r_hiByte;
    logic              r_byteReady;
    logic [ADDR_W-1:0] r_ramAddr;
    logic [WORD_W-1:0] r_ramData;
    logic              r_ramWrite;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_loadCount;
    logic              w_accept;

    assign w_accept = byte_valid && r_byteReady;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start && !abort) w_nextState = S_HI;
            S_HI: begin
                if (abort)         w_nextState = S_IDLE;
                else if (w_accept) w_nextState = S_LO;
            end
            S_LO: begin
                if (abort)         w_nextState = S_IDLE;
                else if (w_accept) w_nextState = S_WRITE;
            end
            S_WRITE: begin
                if (abort)                         w_nextState = S_IDLE;
                else if (r_remaining == c_CNT_ONE) w_nextState = S_DONE;
                else                               w_nextState = S_HI;
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addrCnt   <= '0;
            r_remaining <= '0;
            r_hiByte    <= '0;
            r_byteReady <= 1'b0;
            r_ramAddr   <= '0;
            r_ramData   <= '0;
            r_ramWrite  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_loadCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_byteReady <= (w_nextState == S_HI) || (w_nextState == S_LO);
            r_ramWrite  <= (w_nextState == S_WRITE);
            r_busy      <= (w_nextState != S_IDLE);
            r_done      <= (w_nextState == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_addrCnt   <= base_addr;
                        r_remaining <= (word_count == '0) ? c_FULL : {1'b0, word_count};
                        r_loadCount <= '0;
                    end
                end
                S_HI: begin
                    if (w_accept && !abort) r_hiByte <= byte_in;
                end
                S_LO: begin
                    if (w_accept && !abort) begin
                        r_ramData <= WORD_W'({r_hiByte, byte_in});
                        r_ramAddr <= r_addrCnt;
                    end
                end
                // The strobe of this cycle completes even under abort, so it is counted.
                S_WRITE: begin
                    r_addrCnt   <= r_addrCnt + c_ADDR_ONE;
                    r_remaining <= r_remaining - c_CNT_ONE;
                    r_loadCount <= r_loadCount + c_CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign byte_ready   = r_byteReady;
    assign ram_addr     = r_ramAddr;
    assign ram_data     = r_ramData;
    assign ram_enable   = r_ramWrite;
    assign ram_write_en = r_ramWrite;
    assign busy         = r_busy;
    assign done         = r_done;
    assign load_count   = r_loadCount;

endmodule
`default_nettype wire

// File: tb/tb_instr_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_ram_loader
//  Description : Scoreboard bench: drivers queue expected RAM writes, a monitor
//                pops and compares them whenever the write strobe is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_ram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic        ram_enable;
    logic        ram_write_en;
    logic        busy;
    logic        done;
    logic [8:0]  load_count;

    instr_ram_loader #(.ADDR_W(8), .WORD_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_enable(ram_enable),
        .ram_write_en(ram_write_en), .busy(busy), .done(done), .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         expQ[$];
    logic [15:0] wordSrc[$];
    int cmpCount = 0;
    int errCount = 0;
    int cyc = 0;
    int lastWrCyc = 0;
    int lastDoneCyc = 0;
    wr_t monE;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A write seen while reset is low is not treated as a RAM write.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (ram_enable !== ram_write_en) check("enable_vs_write_en", 32'(ram_enable), 32'(ram_write_en));
            if (ram_write_en === 1'b1) begin
                lastWrCyc = cyc;
                cmpCount++;
                if (expQ.size() == 0) begin
                    errCount++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_data);
                end else begin
                    monE = expQ.pop_front();
                    if (ram_addr !== monE.a || ram_data !== monE.d) begin
                        errCount++;
                        $display("FAIL ram_write: got %0h<=%0h expected %0h<=%0h", ram_addr, ram_data, monE.a, monE.d);
                    end
                end
            end
            if (done === 1'b1) lastDoneCyc = cyc;
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap, input bit chkReady);
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(negedge clk);
            if (chkReady) check("ready_in_stall", 32'(byte_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                return;
            end
        end
        cmpCount++;
        errCount++;
        $display("FAIL byte_accept_timeout: got no byte_ready expected accept of %0h", b);
        byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] addr, input logic [15:0] w, input int gap, input bit expectWrite);
        if (expectWrite) expQ.push_back('{a: addr, d: w});
        sendByte(w[15:8], gap, 1'b0);
        sendByte(w[7:0], gap, gap > 0);
    endtask

    task automatic startSession(input logic [7:0] base, input logic [7:0] wc);
        start      = 1'b1;
        base_addr  = base;
        word_count = wc;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 8'($urandom);
        word_count = 8'($urandom);
    endtask

    task automatic runSession(input logic [7:0] base, input logic [7:0] wc,
                              input int gMin, input int gMax, input bit poke);
        int n;
        bit got;
        logic [15:0] w;
        n = (wc == 8'd0) ? 256 : int'(wc);
        startSession(base, wc);
        for (int i = 0; i < n; i++) begin
            w = (wordSrc.size() > 0) ? wordSrc.pop_front() : 16'($urandom);
            sendWord(8'(int'(base) + i), w, int'($urandom_range(gMax, gMin)), 1'b1);
            if (poke && i == 0) begin
                start      = 1'b1;
                base_addr  = 8'h00;
                word_count = 8'd5;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        check("done_pulse", 32'(got), 32'd1);
        check("done_after_last_write", 32'(lastDoneCyc - lastWrCyc), 32'd1);
        check("load_count", 32'(load_count), 32'(n));
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("queue_drained", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_write_en", 32'(ram_write_en), 32'd0);
        check("rst_enable", 32'(ram_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0; byte_valid = 1'b0; byte_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed basic load, then the same data with 3-cycle stalls
        wordSrc = '{16'hA53C, 16'h1234};
        runSession(8'h10, 8'd2, 0, 0, 1'b0);
        wordSrc = '{16'hA53C, 16'h1234};
        runSession(8'h10, 8'd2, 3, 3, 1'b0);

        // Address wrap and full 256-word session
        runSession(8'hFF, 8'd2, 0, 1, 1'b0);
        runSession(8'h40, 8'd0, 0, 0, 1'b0);

        // Abort in LO after one completed word
        startSession(8'h20, 8'd3);
        sendWord(8'h20, 16'($urandom), 0, 1'b1);
        sendByte(8'h77, 0, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(byte_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_load_count", 32'(load_count), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_queue", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
        runSession(8'($urandom), 8'd3, 0, 2, 1'b0);

        // Reset during WRITE of the second word, start held high meanwhile
        b = 8'($urandom);
        startSession(b, 8'd3);
        sendWord(b, 16'($urandom), 0, 1'b1);
        sendWord(8'(b + 8'd1), 16'($urandom), 0, 1'b0);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetOutputs();
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);
        check("reset_queue", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;

        // Start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_ready", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;

        // Start pulsed mid-session is ignored
        runSession(8'h80, 8'd3, 0, 1, 1'b1);

        // Randomized sessions
        for (int s = 0; s < 6; s++)
            runSession(8'($urandom), 8'($urandom_range(8, 1)), 0, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_ram_loader.md
INSTR_RAM_LOADER -- requirements
Module: instr_ram_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction RAM address width.
REQ-002 Parameter WORD_W, default 16, instruction word width: opcode [15:11], address mode [10:8], data [7:0].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 start  input  1  begins a load session when sampled high in IDLE.
REQ-006 abort  input  1  ends the session immediately; any partial word is discarded.
REQ-007 base_addr  input  ADDR_W  first RAM address of the session, captured on start.
REQ-008 word_count  input  ADDR_W  number of words to load, captured on start; 0 means 2^ADDR_W.
REQ-009 byte_valid  input  1  byte_in is valid this cycle.
REQ-010 byte_in  input  8  serial program byte.
REQ-011 byte_ready  output  1  loader accepts a byte this cycle.
REQ-012 ram_addr  output  ADDR_W  instruction RAM write address.
REQ-013 ram_data  output  WORD_W  instruction RAM write data.
REQ-014 ram_enable  output  1  RAM enable, asserted with ram_write_en.
REQ-015 ram_write_en  output  1  RAM write strobe, one cycle per word.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.
REQ-018 load_count  output  ADDR_W+1  words written in the current or last session.

Function
REQ-019 State machine states are IDLE, HI, LO, WRITE and DONE.
REQ-020 IDLE with start=1 and abort=0: capture base_addr into the address counter, capture word_count into the remaining counter (0 becomes 2^ADDR_W), clear load_count, and go to HI.
REQ-021 start shall be ignored outside IDLE.
REQ-022 byte_ready shall be 1 only in HI and LO; a byte is accepted only when byte_valid=1 and byte_ready=1.
REQ-023 HI: an accepted byte is stored as word bits [15:8] and the state goes to LO; with no accepted byte, HI holds.
REQ-024 LO: an accepted byte forms ram_data = {high byte, byte_in} and the state goes to WRITE; with no accepted byte, LO holds.
REQ-025 WRITE lasts exactly one cycle, with ram_write_en=1, ram_enable=1, ram_addr = address counter and ram_data stable.
REQ-026 On leaving WRITE:
  - address counter increments, modulo 2^ADDR_W (0xFF wraps to 0x00);
  - remaining counter decrements;
  - load_count increments;
  - next state is DONE if remaining was 1, otherwise HI.
REQ-027 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-028 Minimum throughput is one word per 3 cycles (HI, LO, WRITE) when byte_valid is held high.
REQ-029 Gaps in byte_valid stall HI or LO indefinitely, with no timeout.
REQ-030 abort=1 in HI, LO, WRITE or DONE forces IDLE on the next edge:
  - no RAM write in the cycle after abort is sampled;
  - no done pulse;
  - load_count keeps the words already written.
REQ-031 Priority when events coincide: abort wins over byte acceptance and over start; in WRITE, the write in the current cycle still completes.
REQ-032 ram_write_en and ram_enable shall be 0 in every state other than WRITE.
REQ-033 ram_addr and ram_data shall hold their last values outside WRITE.

Reset
REQ-034 reset=0 at a rising edge forces IDLE regardless of current state, including mid-word and mid-session; no RAM write follows.
REQ-035 Reset values: byte_ready=0, ram_write_en=0, ram_enable=0, busy=0, done=0, ram_addr=0, ram_data=0, load_count=0; internal counters and high-byte register are cleared.

Verification
REQ-036 Basic load: base_addr=0x10, word_count=2, bytes A5,3C,12,34 back-to-back -> write 0x10<=0xA53C, then 0x11<=0x1234; done one cycle after the second write; load_count=2; busy=0 afterwards.
REQ-037 Stalls: same session with byte_valid low for 3 cycles between each byte -> identical writes; byte_ready stays high while waiting; no extra write strobes.
REQ-038 Wrap and zero count:
  - base_addr=0xFF, word_count=2 -> writes to 0xFF then 0x00.
  - word_count=0, base_addr=0x40 -> 256 writes, the last to 0x3F; load_count=256.
REQ-039 Abort: abort asserted in LO after the high byte 0x77 is accepted -> no write, IDLE next cycle, done=0; a following session writes correctly.
REQ-040 Reset mid-session: reset=0 during WRITE of the second word -> the first word is written; outputs return to reset values; start ignored while reset=0.
REQ-041 Coincident events: start pulsed while busy -> ignored; start and abort together in IDLE -> stays in IDLE.
